// File: rtl/time_tmr_collector.sv
// rtl/time_tmr_collector.sv - time-redundant (TMR) replica collector with majority vote and output FIFO
//
// Upstream sends each item up to three times (replicas) tagged with an item ID.
// Replicas are grouped, voted word-wise, de-duplicated against the last emitted
// ID and queued in a small output FIFO. With enable_i low the block drains its
// FIFO and then becomes a combinational passthrough.
//
// Ports:
//   clk_i            clock
//   rst_ni           asynchronous active-low reset
//   enable_i         redundancy enable (0 = drain then passthrough)
//   data_i, id_i     upstream payload and replica/item ID
//   valid_i, ready_o upstream handshake
//   data_o           downstream payload (FIFO head, or data_i in passthrough)
//   valid_o, ready_i downstream handshake
//   fault_detected_o one-cycle pulse after a degraded or disagreeing group
module time_tmr_collector #(
    parameter type         DataType    = logic,
    parameter int unsigned IDSize      = 4,
    parameter int unsigned OutDepth    = 2,
    parameter int unsigned LockTimeout = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  DataType           data_i,
    input  logic [IDSize-1:0] id_i,
    input  logic              valid_i,
    output logic              ready_o,
    output DataType           data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              fault_detected_o
);

    localparam int unsigned PtrW = (OutDepth > 1) ? $clog2(OutDepth) : 1;
    localparam int unsigned CntW = $clog2(OutDepth + 1);
    localparam int unsigned TmrW = (LockTimeout > 1) ? $clog2(LockTimeout) : 1;

    localparam logic [PtrW-1:0]   PTR_LAST = PtrW'(OutDepth - 1);
    localparam logic [PtrW-1:0]   PTR_ONE  = PtrW'(1);
    localparam logic [CntW-1:0]   CNT_FULL = CntW'(OutDepth);
    localparam logic [CntW-1:0]   CNT_ONE  = CntW'(1);
    localparam logic [TmrW-1:0]   TMR_LAST = TmrW'(LockTimeout - 1);
    localparam logic [TmrW-1:0]   TMR_ONE  = TmrW'(1);
    localparam logic [IDSize-1:0] ID_ONE   = IDSize'(1);

    // State is the number of replicas currently held in the open group.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    DataType           slot0_data_q, slot1_data_q;
    logic [IDSize-1:0] slot0_id_q;
    logic [TmrW-1:0]   tmr_q;
    logic [IDSize-1:0] last_id_q;
    logic              last_vld_q;
    logic              fault_q;

    DataType           fifo_mem [OutDepth];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   fifo_cnt_q;

    logic              fifo_empty, fifo_full, fifo_push, fifo_pop;
    logic              accept, is_new, corrected, is_dup;
    logic              close, store0, store1;
    logic [1:0]        n_rep;
    logic              vote_ok, vote_disagree;
    DataType           vote_data;
    logic              fault_d;

    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_full  = (fifo_cnt_q == CNT_FULL);
    // The FIFO head is presented whenever it is non-empty, in either mode.
    assign fifo_pop   = !fifo_empty && ready_i;
    assign accept     = enable_i && valid_i && !fifo_full;
    assign is_new     = (id_i == slot0_id_q + ID_ONE);
    // Any ID that is neither the current item nor its successor is treated as
    // a replica of the current item whose ID was corrupted.
    assign corrected  = accept && (state_q != EMPTY) && !is_new && (id_i != slot0_id_q);
    assign is_dup     = last_vld_q && (slot0_id_q == last_id_q);

    // Group FSM: decides when a group closes and how many replicas it had.
    always_comb begin
        state_d = state_q;
        close   = 1'b0;
        n_rep   = 2'd0;
        store0  = 1'b0;
        store1  = 1'b0;
        if (!enable_i) begin
            state_d = EMPTY;
        end else if (accept) begin
            case (state_q)
                EMPTY: begin
                    store0  = 1'b1;
                    state_d = ONE;
                end
                ONE: begin
                    if (is_new) begin
                        close   = 1'b1;
                        n_rep   = 2'd1;
                        store0  = 1'b1;
                        state_d = ONE;
                    end else begin
                        store1  = 1'b1;
                        state_d = TWO;
                    end
                end
                TWO: begin
                    close = 1'b1;
                    if (is_new) begin
                        n_rep   = 2'd2;
                        store0  = 1'b1;
                        state_d = ONE;
                    end else begin
                        // Third replica is voted straight from data_i.
                        n_rep   = 2'd3;
                        state_d = EMPTY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end else if ((state_q != EMPTY) && (tmr_q == TMR_LAST) && !fifo_full) begin
            close   = 1'b1;
            n_rep   = (state_q == TWO) ? 2'd2 : 2'd1;
            state_d = EMPTY;
        end
    end

    // Word-level majority vote over slot0, slot1 and the incoming beat.
    always_comb begin
        vote_ok       = 1'b0;
        vote_disagree = 1'b0;
        vote_data     = slot0_data_q;
        case (n_rep)
            2'd3: begin
                vote_disagree = !((slot0_data_q == slot1_data_q) && (slot1_data_q == data_i));
                if ((slot0_data_q == slot1_data_q) || (slot0_data_q == data_i)) begin
                    vote_ok = 1'b1;
                end else if (slot1_data_q == data_i) begin
                    vote_ok   = 1'b1;
                    vote_data = slot1_data_q;
                end
            end
            2'd2: begin
                vote_ok       = (slot0_data_q == slot1_data_q);
                vote_disagree = !vote_ok;
            end
            default: ;
        endcase
    end

    // Space is guaranteed at close: beats are only accepted and timeouts only
    // fire while the FIFO is not full.
    assign fifo_push = close && vote_ok && !is_dup;
    assign fault_d   = corrected || (close && ((n_rep != 2'd3) || vote_disagree || !vote_ok));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= EMPTY;
            slot0_data_q <= '0;
            slot1_data_q <= '0;
            slot0_id_q   <= '0;
            tmr_q        <= '0;
            last_id_q    <= '0;
            last_vld_q   <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            if (store0) begin
                slot0_data_q <= data_i;
                slot0_id_q   <= id_i;
            end
            if (store1) begin
                slot1_data_q <= data_i;
            end
            if (!enable_i || accept || close || (state_q == EMPTY)) begin
                tmr_q <= '0;
            end else if (tmr_q != TMR_LAST) begin
                tmr_q <= tmr_q + TMR_ONE;
            end
            if (!enable_i) begin
                last_vld_q <= 1'b0;
            end else if (fifo_push) begin
                last_vld_q <= 1'b1;
                last_id_q  <= slot0_id_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            for (int i = 0; i < OutDepth; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (fifo_push) begin
                fifo_mem[wr_ptr_q] <= vote_data;
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
            end
            if (fifo_pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_ONE;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_ONE;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // Disabled: drain the FIFO with upstream stalled, then pass straight through.
    always_comb begin
        ready_o = !fifo_full;
        valid_o = !fifo_empty;
        data_o  = fifo_mem[rd_ptr_q];
        if (!enable_i) begin
            if (fifo_empty) begin
                ready_o = ready_i;
                valid_o = valid_i;
                data_o  = data_i;
            end else begin
                ready_o = 1'b0;
            end
        end
    end

    assign fault_detected_o = fault_q;

endmodule

// File: tb/tb_time_tmr_collector.sv
// tb/tb_time_tmr_collector.sv - self-checking bench for time_tmr_collector
module tb_time_tmr_collector;

    logic       clk = 1'b0;
    logic       rst_ni, enable_i, valid_i, ready_i;
    logic [7:0] data_i, data_o;
    logic [3:0] id_i;
    logic       ready_o, valid_o, fault_detected_o;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         out_cnt = 0;
    int         fault_cnt = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    time_tmr_collector #(
        .DataType    (logic [7:0]),
        .IDSize      (4),
        .OutDepth    (2),
        .LockTimeout (4)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .enable_i         (enable_i),
        .data_i           (data_i),
        .id_i             (id_i),
        .valid_i          (valid_i),
        .ready_o          (ready_o),
        .data_o           (data_o),
        .valid_o          (valid_o),
        .ready_i          (ready_i),
        .fault_detected_o (fault_detected_o)
    );

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic [3:0] id);
        int w;
        w = 0;
        valid_i = 1'b1;
        data_i  = d;
        id_i    = id;
        @(negedge clk);
        while (ready_o !== 1'b1 && w < 50) begin
            w++;
            @(negedge clk);
        end
        if (w >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL beat_accept_timeout: ready_o=%b, required 1", ready_o);
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic do_reset();
        valid_i = 1'b0;
        rst_ni  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; enable_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        data_i = 8'h00; id_i = 4'h0;
        idle(1);
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b, required 0", valid_o); end
        n_cmp++; if (fault_detected_o !== 1'b0) begin n_bad++; $display("FAIL reset_fault: got %b, required 0", fault_detected_o); end
        n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready_en: got %b, required 1", ready_o); end
        enable_i = 1'b0; ready_i = 1'b0; #1;
        n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready_dis0: got %b, required 0", ready_o); end
        ready_i = 1'b1; #1;
        n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready_dis1: got %b, required 1", ready_o); end
        enable_i = 1'b1;
        do_reset();
    endtask

    task automatic test_basic();
        int f0;
        do_reset();
        ready_i = 1'b1; f0 = fault_cnt;
        exp_q.push_back(8'h5A);
        send_beat(8'h5A, 4'd1);
        send_beat(8'h5A, 4'd1);
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid: got %b, required 0", valid_o); end
        send_beat(8'h5A, 4'd1);
        n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL basic_latency_valid: got %b, required 1", valid_o); end
        n_cmp++; if (data_o !== 8'h5A) begin n_bad++; $display("FAIL basic_latency_data: got %02h, required 5a", data_o); end
        idle(4);
        n_cmp++; if (fault_cnt != f0) begin n_bad++; $display("FAIL basic_fault: got %0d pulses, required 0", fault_cnt - f0); end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL basic_drain: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_vote();
        int f0, o0;
        do_reset();
        ready_i = 1'b1; f0 = fault_cnt;
        exp_q.push_back(8'h5A);
        send_beat(8'h5A, 4'd1);
        send_beat(8'h7E, 4'd1);
        send_beat(8'h5A, 4'd1);
        idle(4);
        n_cmp++; if (fault_cnt == f0) begin n_bad++; $display("FAIL vote_minority_fault: got 0 pulses, required >=1"); end
        f0 = fault_cnt; o0 = out_cnt;
        send_beat(8'h11, 4'd2);
        send_beat(8'h22, 4'd2);
        send_beat(8'h33, 4'd2);
        idle(4);
        n_cmp++; if (fault_cnt == f0) begin n_bad++; $display("FAIL vote_nomajority_fault: got 0 pulses, required >=1"); end
        n_cmp++; if (out_cnt != o0) begin n_bad++; $display("FAIL vote_nomajority_drop: got %0d items, required 0", out_cnt - o0); end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL vote_drain: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_id_fix();
        int f0, o0;
        do_reset();
        ready_i = 1'b1; f0 = fault_cnt; o0 = out_cnt;
        exp_q.push_back(8'hC3);
        send_beat(8'hC3, 4'd3);
        send_beat(8'hC3, 4'd9);
        send_beat(8'hC3, 4'd3);
        idle(4);
        n_cmp++; if (fault_cnt == f0) begin n_bad++; $display("FAIL idfix_fault: got 0 pulses, required >=1"); end
        n_cmp++; if (out_cnt != o0 + 1) begin n_bad++; $display("FAIL idfix_count: got %0d items, required 1", out_cnt - o0); end
        f0 = fault_cnt;
        exp_q.push_back(8'h44);
        send_beat(8'h44, 4'd4);
        send_beat(8'h44, 4'd4);
        send_beat(8'h44, 4'd4);
        idle(4);
        n_cmp++; if (fault_cnt != f0) begin n_bad++; $display("FAIL idfix_clean_fault: got %0d pulses, required 0", fault_cnt - f0); end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL idfix_drain: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_timeout();
        int f0, o0;
        do_reset();
        ready_i = 1'b1; f0 = fault_cnt;
        exp_q.push_back(8'hAA);
        send_beat(8'hAA, 4'd5);
        send_beat(8'hAA, 4'd5);
        idle(3);
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL timeout_early: got valid %b, required 0", valid_o); end
        idle(1);
        n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL timeout_valid: got %b, required 1", valid_o); end
        n_cmp++; if (data_o !== 8'hAA) begin n_bad++; $display("FAIL timeout_data: got %02h, required aa", data_o); end
        idle(2);
        n_cmp++; if (fault_cnt == f0) begin n_bad++; $display("FAIL timeout_fault: got 0 pulses, required >=1"); end
        o0 = out_cnt;
        send_beat(8'hAA, 4'd5);
        idle(10);
        n_cmp++; if (out_cnt != o0) begin n_bad++; $display("FAIL timeout_late_drop: got %0d items, required 0", out_cnt - o0); end
    endtask

    task automatic test_back_to_back();
        int o0;
        do_reset();
        ready_i = 1'b0; o0 = out_cnt;
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h30);
        for (int k = 0; k < 3; k++) send_beat(8'h10, 4'd1);
        for (int k = 0; k < 3; k++) send_beat(8'h20, 4'd2);
        n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready: got %b, required 0", ready_o); end
        n_cmp++; if (data_o !== 8'h10) begin n_bad++; $display("FAIL bp_head: got %02h, required 10", data_o); end
        fork
            begin
                for (int k = 0; k < 3; k++) send_beat(8'h30, 4'd3);
            end
            begin
                idle(5);
                n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL bp_hold_ready: got %b, required 0", ready_o); end
                ready_i = 1'b1;
            end
        join
        idle(5);
        n_cmp++; if (out_cnt != o0 + 3) begin n_bad++; $display("FAIL bp_count: got %0d items, required 3", out_cnt - o0); end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL bp_drain: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_disable();
        int o0;
        do_reset();
        ready_i = 1'b0;
        exp_q.push_back(8'h66);
        for (int k = 0; k < 3; k++) send_beat(8'h66, 4'd6);
        enable_i = 1'b0; valid_i = 1'b0; data_i = 8'h77; #1;
        n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL dis_drain_ready: got %b, required 0", ready_o); end
        n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL dis_drain_valid: got %b, required 1", valid_o); end
        n_cmp++; if (data_o !== 8'h66) begin n_bad++; $display("FAIL dis_drain_data: got %02h, required 66", data_o); end
        ready_i = 1'b1;
        idle(1);
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL dis_pass_idle: got %b, required 0", valid_o); end
        n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL dis_pass_ready: got %b, required 1", ready_o); end
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(8'h80 + 8'(k));
            data_i = 8'h80 + 8'(k); id_i = 4'(k + 11); valid_i = 1'b1;
            idle(1);
        end
        valid_i = 1'b0;
        idle(1);
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL dis_pass_drain: got %0d pending, required 0", exp_q.size()); end
        enable_i = 1'b1; ready_i = 1'b0;
        for (int k = 0; k < 3; k++) send_beat(8'h55, 4'd8);
        send_beat(8'h56, 4'd9);
        rst_ni = 1'b0;
        idle(1);
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %b, required 0", valid_o); end
        ready_i = 1'b1;
        rst_ni = 1'b1;
        o0 = out_cnt;
        idle(10);
        n_cmp++; if (out_cnt != o0) begin n_bad++; $display("FAIL rst_mid_discard: got %0d items, required 0", out_cnt - o0); end
        exp_q.push_back(8'h58);
        for (int k = 0; k < 3; k++) send_beat(8'h58, 4'd1);
        idle(3);
        n_cmp++; if (out_cnt != o0 + 1) begin n_bad++; $display("FAIL rst_after_item: got %0d items, required 1", out_cnt - o0); end
    endtask

    initial begin
        fork
            forever begin
                logic [7:0] e;
                @(negedge clk);
                if (rst_ni === 1'b1) begin
                    if (fault_detected_o === 1'b1) fault_cnt++;
                    if (valid_o === 1'b1 && ready_i === 1'b1) begin
                        out_cnt++;
                        n_cmp++;
                        if (exp_q.size() == 0) begin
                            n_bad++;
                            $display("FAIL sb_unexpected: got item %02h, required none", data_o);
                        end else begin
                            e = exp_q.pop_front();
                            if (data_o !== e) begin
                                n_bad++;
                                $display("FAIL sb_data: got %02h, required %02h", data_o, e);
                            end
                        end
                    end
                end
            end
        join_none
        test_reset();
        test_basic();
        test_vote();
        test_id_fix();
        test_timeout();
        test_back_to_back();
        test_disable();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
